pilha_retorno: RTL
==================

Name: pilha_retorno

Overview:
- Return-address stack (RAS) for the fetch stage.
- It consumes the same PC+1 link value that JAL/JALR write back to the register file.
- It pushes that value on every link jump and pops it on every JALR return, giving fetch a predicted return target (`endereco_previsto`) before the register-file read of JALR resolves.
- Sits beside the PC logic; its output is compared against the real JALR target in execute.

Parameters:
- ADDR_WIDTH, 13, width of PC / return address.
- DEPTH, 8, number of stack entries; must be a power of two, ≥ 2.
- PTR_WIDTH, 3, log2(DEPTH); must be kept consistent with DEPTH.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- habilita  input  1  pipeline advance. When 0, the stack holds all state and ignores `empilha`/`desempilha`.
- proximo_pc  input  ADDR_WIDTH  PC+1 of the jumping instruction (value to push).
- empilha  input  1  push request. Driven by `jump_al`, or by `jalr` with rd = return register.
- desempilha  input  1  pop request. Driven by `jalr` with rs = return register.
- endereco_previsto  output  ADDR_WIDTH  current top-of-stack. Forced to 0 when the stack is empty.
- previsao_valida  output  1  1 when stack count > 0.
- vazia  output  1  count = 0.
- cheia  output  1  count = DEPTH.
- transbordou  output  1  sticky: a push occurred while full (oldest entry lost).
- subfluxo  output  1  sticky: a pop occurred while empty.

Behaviour:
- **Storage:**
  - Circular array `mem[DEPTH]` of ADDR_WIDTH bits.
  - Top pointer `topo` (PTR_WIDTH bits, wraps modulo DEPTH).
  - Occupancy `contagem` (PTR_WIDTH+1 bits, range 0..DEPTH).
- **Reset (reset=0 at clock edge):**
  - `topo` = DEPTH-1, so the first push lands in entry 0.
  - `contagem` = 0; `transbordou` = 0; `subfluxo` = 0.
  - `mem` contents are don't-care.
  - Resulting outputs: `endereco_previsto` = 0, `previsao_valida` = 0, `vazia` = 1, `cheia` = 0.
  - Reset overrides any simultaneous push or pop.
- **Output read:**
  - Outputs are combinational from registered state: `endereco_previsto` = `mem[topo]` when `contagem` > 0, else 0.
  - A push at edge N is visible on `endereco_previsto` immediately after edge N (1-cycle latency).
- **Operation table (habilita=1), by empilha/desempilha:**
  - 0/0: hold.
  - 1/0, push:
    - `topo` = `topo`+1 (wrap); `mem[topo+1]` = `proximo_pc`.
    - `contagem` = min(`contagem`+1, DEPTH).
    - If `contagem` was DEPTH, the oldest entry is overwritten and `transbordou` is set to 1.
  - 0/1, pop:
    - If `contagem` > 0: `topo` = `topo`-1 (wrap), `contagem` = `contagem`-1.
    - If `contagem` = 0: no pointer change, and `subfluxo` is set to 1.
  - 1/1, replace (JALR that also links):
    - `mem[topo]` = `proximo_pc`; `topo` and `contagem` unchanged.
    - If `contagem` was 0, this behaves as a push (`contagem` = 1, `topo`+1, write) and sets `subfluxo`.
- **Hold / clear rules:**
  - habilita=0 with reset=1: nothing changes, including sticky flags.
  - Sticky flags clear only on reset.
- **Width rules:**
  - Pointer arithmetic is modulo DEPTH with no extra logic (natural PTR_WIDTH wrap).
  - `contagem` never exceeds DEPTH and never underflows.
- **Reset mid-operation:** a pending push or pop in the same cycle as reset=0 is discarded.

Test Plan:
1. Reset → `vazia`=1, `previsao_valida`=0, `endereco_previsto`=0, `cheia`=0, both sticky flags 0.
2. Push 0x0010, 0x0020, 0x0030, then pop, pop →
   - top reads 0x0030 after the pushes;
   - then 0x0020 after the first pop;
   - then 0x0010 after the second pop;
   - `contagem` 3→2→1.
3. Push DEPTH+1 values 0x100..0x108 (DEPTH=8) →
   - `cheia`=1 after the 8th push;
   - `transbordou`=1 after the 9th;
   - top = 0x108;
   - popping 8 times yields 0x108 down to 0x101; value 0x100 is lost;
   - then `vazia`=1.
4. Pop on empty → `subfluxo`=1, `contagem` stays 0, `endereco_previsto`=0. A following push of 0x0AA → top = 0x0AA, `contagem`=1.
5. Stack holds 0x0040, 0x0050; assert empilha=desempilha=1 with `proximo_pc`=0x0077 → top = 0x0077, `contagem` stays 2; a pop then exposes 0x0040.
6. Assert habilita=0 with empilha=1, then reset=0 together with empilha=1 →
   - no change while habilita=0;
   - after the reset cycle, all outputs are back at reset values.

Source files
------------

// File: rtl/pilha_retorno.sv
// rtl/pilha_retorno.sv - return-address stack predicting JALR targets for fetch
module pilha_retorno #(
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  habilita,
    input  logic [ADDR_WIDTH-1:0] proximo_pc,
    input  logic                  empilha,
    input  logic                  desempilha,
    output logic [ADDR_WIDTH-1:0] endereco_previsto,
    output logic                  previsao_valida,
    output logic                  vazia,
    output logic                  cheia,
    output logic                  transbordou,
    output logic                  subfluxo
);

    localparam logic [PTR_WIDTH:0]   CONT_CHEIA = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_UM     = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   CONT_UM    = (PTR_WIDTH+1)'(1);

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  topo_q, topo_d;
    logic [PTR_WIDTH:0]    contagem_q, contagem_d;
    logic                  transbordou_q, transbordou_d;
    logic                  subfluxo_q, subfluxo_d;

    logic                  wr_en;
    logic [PTR_WIDTH-1:0]  wr_addr;
    logic                  esta_vazia, esta_cheia;

    assign esta_vazia = (contagem_q == '0);
    assign esta_cheia = (contagem_q == CONT_CHEIA);

    always_comb begin
        topo_d        = topo_q;
        contagem_d    = contagem_q;
        transbordou_d = transbordou_q;
        subfluxo_d    = subfluxo_q;
        wr_en         = 1'b0;
        wr_addr       = topo_q;
        if (habilita) begin
            case ({empilha, desempilha})
                2'b10: begin
                    topo_d  = topo_q + PTR_UM;
                    wr_en   = 1'b1;
                    wr_addr = topo_q + PTR_UM;
                    // When full, the slot above topo is the oldest entry: overwrite it.
                    if (esta_cheia) transbordou_d = 1'b1;
                    else            contagem_d    = contagem_q + CONT_UM;
                end
                2'b01: begin
                    if (esta_vazia) begin
                        subfluxo_d = 1'b1;
                    end else begin
                        topo_d     = topo_q - PTR_UM;
                        contagem_d = contagem_q - CONT_UM;
                    end
                end
                2'b11: begin
                    wr_en = 1'b1;
                    // Replace on empty has nothing to pop, so it degrades to a push.
                    if (esta_vazia) begin
                        subfluxo_d = 1'b1;
                        topo_d     = topo_q + PTR_UM;
                        wr_addr    = topo_q + PTR_UM;
                        contagem_d = CONT_UM;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            topo_q        <= PTR_WIDTH'(DEPTH - 1);
            contagem_q    <= '0;
            transbordou_q <= 1'b0;
            subfluxo_q    <= 1'b0;
        end else begin
            topo_q        <= topo_d;
            contagem_q    <= contagem_d;
            transbordou_q <= transbordou_d;
            subfluxo_q    <= subfluxo_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && wr_en) mem_q[wr_addr] <= proximo_pc;
    end

    assign endereco_previsto = esta_vazia ? '0 : mem_q[topo_q];
    assign previsao_valida   = !esta_vazia;
    assign vazia             = esta_vazia;
    assign cheia             = esta_cheia;
    assign transbordou       = transbordou_q;
    assign subfluxo          = subfluxo_q;

endmodule
